// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter, one serial bit per clk.
// Frame: start bit (0), DATA_WIDTH payload bits LSB first, optional parity bit,
// then STOP_BITS stop bits (1). The line idles high.
// Optional feature: define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry
// descriptor FIFO between the accept handshake and the frame FSM. Without it,
// a frame is accepted only while the transmitter is idle.
module uart_tx_param #(
  parameter int DATA_WIDTH = 8,  // payload bits per frame, 5..16
  parameter int STOP_BITS  = 1,  // stop-bit cycles, 1 or 2
  parameter int FIFO_DEPTH = 4   // descriptor entries, power of two >= 2
) (
  input  logic                  clk,
  input  logic                  reset,      // synchronous, active low
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,    // 0 = even, 1 = odd
  output logic                  DATA_READY,
  output logic                  TX_OUT,
  output logic                  Busy
);

  // A frame descriptor is {parity type, parity enable, payload}.
  localparam int DESC_W = DATA_WIDTH + 2;
  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;

  logic                    accept;      // handshake completes on this edge
  logic [DESC_W-1:0]       in_desc;
  logic                    pend_valid;  // a frame is available to the FSM
  logic [DESC_W-1:0]       pend_desc;
  logic                    load;        // FSM takes the pending frame this edge

  assign in_desc = {PAR_TYP, PAR_EN, P_DATA};
  // Nothing is accepted while reset is held.
  assign accept  = reset && DATA_VALID && DATA_READY;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  // Small descriptor store; read asynchronously so a pop can start a frame
  // in the same edge, which keeps back-to-back frames gapless.
  logic [DESC_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  assign DATA_READY = (count_q != FULL_CNT);
  assign pend_valid = (count_q != '0);
  assign pend_desc  = mem_q[rd_ptr_q];

  // FIFO pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (load)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({accept, load})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Descriptor storage write on accept.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= in_desc;
  end
`else
  // Without a queue the accepted descriptor goes straight into the FSM.
  assign DATA_READY = !Busy;
  assign pend_valid = accept;
  assign pend_desc  = in_desc;
`endif

  // State register: FSM state, bit counter and the captured frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Next-state logic: walk start/data/parity/stop, chaining frames from STOP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pend_valid) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        cnt_d   = '0;
        state_d = S_STOP;
      end
      S_STOP: begin
        if (cnt_q == LAST_STOP) begin
          cnt_d = '0;
          if (pend_valid) begin
            load    = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    // Capture the whole descriptor at once so later input changes are ignored.
    if (load) begin
      shift_d   = pend_desc[DATA_WIDTH-1:0];
      par_en_d  = pend_desc[DATA_WIDTH];
      par_bit_d = (^pend_desc[DATA_WIDTH-1:0]) ^ pend_desc[DATA_WIDTH+1];
    end
  end

  // Output logic: serial line level and busy flag from the current state.
  always_comb begin
    TX_OUT = 1'b1;
    Busy   = (state_q != S_IDLE);
    case (state_q)
      S_START:  TX_OUT = 1'b0;
      S_DATA:   TX_OUT = shift_q[0];
      S_PARITY: TX_OUT = par_bit_q;
      default:  TX_OUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: default instance (8 data bits, 1 stop)
// and a 5-bit / 2-stop instance. FIFO-specific steps compile only when
// UART_TX_FIFO_EN is defined, matching the design build.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] p_data0;
  logic       dv0, pe0, pt0;
  logic       rdy0, tx0, busy0;
  logic [4:0] p_data1;
  logic       dv1, pe1, pt1;
  logic       rdy1, tx1, busy1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_param dut0 (
    .clk(clk), .reset(rst_n), .P_DATA(p_data0), .DATA_VALID(dv0),
    .PAR_EN(pe0), .PAR_TYP(pt0), .DATA_READY(rdy0), .TX_OUT(tx0), .Busy(busy0)
  );

  uart_tx_param #(.DATA_WIDTH(5), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(rst_n), .P_DATA(p_data1), .DATA_VALID(dv1),
    .PAR_EN(pe1), .PAR_TYP(pt1), .DATA_READY(rdy1), .TX_OUT(tx1), .Busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Expected line levels read left to right from seq (first bit = start bit).
  task automatic check_seq(input string tag, input int which,
                           input logic [15:0] seq, input int len);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s bit%0d", tag, i), (which == 1) ? tx1 : tx0, seq[len-1-i]);
      chk($sformatf("%s busy%0d", tag, i), (which == 1) ? busy1 : busy0, 1'b1);
      tick();
    end
    chk($sformatf("%s end_busy", tag), (which == 1) ? busy1 : busy0, 1'b0);
    chk($sformatf("%s end_tx", tag), (which == 1) ? tx1 : tx0, 1'b1);
    $display("frame %s: %0d bits checked", tag, len);
  endtask

  // Accept on dut0 and advance to the cycle where the start bit shows.
  task automatic accept0(input logic [7:0] d, input logic pe, input logic pt);
    p_data0 = d; pe0 = pe; pt0 = pt; dv0 = 1'b1;
    tick();
    dv0 = 1'b0;
`ifdef UART_TX_FIFO_EN
    tick();
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    p_data0 = '0; dv0 = 1'b0; pe0 = 1'b0; pt0 = 1'b0;
    p_data1 = '0; dv1 = 1'b0; pe1 = 1'b0; pt1 = 1'b0;
    tick();
    tick();
    chk("rst tx0", tx0, 1'b1);
    chk("rst busy0", busy0, 1'b0);
    chk("rst rdy0", rdy0, 1'b1);
    chk("rst tx1", tx1, 1'b1);
    chk("rst busy1", busy1, 1'b0);
    rst_n = 1'b1;
    tick();

    // 0xA5 without parity, then with even and odd parity.
    accept0(8'hA5, 1'b0, 1'b0);
    check_seq("a5_nopar", 0, 16'b0101001011, 10);
    accept0(8'hA5, 1'b1, 1'b0);
    check_seq("a5_even", 0, 16'b01010010101, 11);
    accept0(8'hA5, 1'b1, 1'b1);
    check_seq("a5_odd", 0, 16'b01010010111, 11);

    // 5 data bits, 2 stop bits.
    p_data1 = 5'h1F; dv1 = 1'b1;
    tick();
    dv1 = 1'b0;
`ifdef UART_TX_FIFO_EN
    tick();
`endif
    check_seq("w5s2_1f", 1, 16'b01111111, 8);

`ifndef UART_TX_FIFO_EN
    // Valid held with new data during a frame: ignored until the idle gap.
    p_data0 = 8'hA5; pe0 = 1'b0; pt0 = 1'b0; dv0 = 1'b1;
    tick();
    p_data0 = 8'hFF; pe0 = 1'b1; pt0 = 1'b1;
    chk("busy rdy0", rdy0, 1'b0);
    check_seq("a5_held", 0, 16'b0101001011, 10);
    chk("gap rdy0", rdy0, 1'b1);
    tick();
    dv0 = 1'b0;
    check_seq("ff_odd", 0, 16'b01111111111, 11);
`else
    // Six pushes into a 4-deep FIFO: flow control stalls, output stays gapless.
    begin
      logic saw_full;
      saw_full = 1'b0;
      fork
        begin
          for (int k = 1; k <= 6; k++) begin
            int guard;
            guard = 0;
            p_data0 = 8'(k); pe0 = 1'b0; pt0 = 1'b0; dv0 = 1'b1;
            while (!rdy0 && guard < 40) begin
              saw_full = 1'b1;
              guard++;
              tick();
            end
            if (guard >= 40) chk("push timeout", rdy0, 1'b1);
            tick();
          end
          dv0 = 1'b0;
        end
        begin
          tick();
          tick();
          for (int k = 1; k <= 6; k++) begin
            logic [7:0] d;
            d = 8'(k);
            chk($sformatf("q%0d start", k), tx0, 1'b0);
            tick();
            for (int b = 0; b < 8; b++) begin
              chk($sformatf("q%0d bit%0d", k, b), tx0, d[b]);
              tick();
            end
            chk($sformatf("q%0d stop", k), tx0, 1'b1);
            chk($sformatf("q%0d busy", k), busy0, 1'b1);
            tick();
            $display("frame q%0d: data %02h checked", k, d);
          end
          chk("q end_busy", busy0, 1'b0);
        end
      join
      chk("q saw_full", saw_full, 1'b1);
    end
`endif

    // Reset during data bit 3 aborts everything, queued frames included.
`ifdef UART_TX_FIFO_EN
    p_data0 = 8'h3C; pe0 = 1'b0; dv0 = 1'b1;
    tick();
    p_data0 = 8'h11;
    tick();
    p_data0 = 8'h22;
    tick();
    dv0 = 1'b0;
    tick(); tick(); tick();
`else
    accept0(8'h3C, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
`endif
    chk("pre_rst bit3", tx0, 1'b1);
    chk("pre_rst busy", busy0, 1'b1);
    rst_n = 1'b0; dv0 = 1'b1; p_data0 = 8'h00;
    tick();
    dv0 = 1'b0;
    chk("midrst tx0", tx0, 1'b1);
    chk("midrst busy0", busy0, 1'b0);
    chk("midrst rdy0", rdy0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk($sformatf("post_rst tx%0d", i), tx0, 1'b1);
      chk($sformatf("post_rst busy%0d", i), busy0, 1'b0);
    end
    $display("frame reset_abort: idle line checked");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
